// File: rtl/fetch_align_buffer_if.sv
// Bundles the I-cache fill and decode handshake signals of the fetch align buffer.
// The master side is the buffer itself; the slave side is the cache/decode environment.
interface fetch_align_buffer_if;
  logic [31:0]  IC_ADDR;
  logic [127:0] IC_LINE;
  logic         IC_VALID;
  logic         IC_READY;
  logic [127:0] IR;
  logic         IR_VALID;
  logic [31:0]  EIP;
  logic         D_CONSUME;
  logic [3:0]   D_LENGTH;
  logic         REDIRECT;
  logic [31:0]  REDIRECT_EIP;

  modport master (
    output IC_ADDR, IC_READY, IR, IR_VALID, EIP,
    input  IC_LINE, IC_VALID, D_CONSUME, D_LENGTH, REDIRECT, REDIRECT_EIP
  );

  modport slave (
    input  IC_ADDR, IC_READY, IR, IR_VALID, EIP,
    output IC_LINE, IC_VALID, D_CONSUME, D_LENGTH, REDIRECT, REDIRECT_EIP
  );
endinterface

// File: rtl/fetch_align_buffer.sv
// Byte-aligning instruction fetch buffer: a 32-byte circular buffer filled with
// 16-byte cache lines, presenting a 16-byte window rotated so that the next
// instruction's first byte sits in IR[7:0].
module fetch_align_buffer #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_align_buffer_if.master bus
);

  typedef enum logic {ALIGN = 1'b0, STREAM = 1'b1} state_t;

  state_t       r_state;
  logic [7:0]   r_buf [32];
  logic [4:0]   r_head;
  logic [5:0]   r_count;
  logic         r_wrHalf;
  logic [27:0]  r_fa;
  logic [31:0]  r_eip;
  logic [3:0]   r_skip;

  logic         w_icReady;
  logic         w_irValid;
  logic         w_fill;
  logic         w_consume;
  logic [5:0]   w_fillAmt;
  logic [5:0]   w_consAmt;
  logic [127:0] w_ir;

  // The buffer only takes a line when the free half is guaranteed empty; a
  // redirect in the same cycle blocks the handshake so the cache keeps the line.
  assign w_icReady = (r_count <= 6'd16) && !bus.REDIRECT;
  assign w_irValid = (r_count >= 6'd16);
  assign w_fill    = bus.IC_VALID && w_icReady;
  assign w_consume = bus.D_CONSUME && w_irValid && (bus.D_LENGTH != 4'd0);
  assign w_fillAmt = w_fill ? 6'd16 : 6'd0;
  assign w_consAmt = w_consume ? {2'b00, bus.D_LENGTH} : 6'd0;

  // Rotate the circular buffer so the head byte lands in the lowest lane; the
  // 5-bit index wraps naturally across the 31->0 boundary.
  always_comb begin
    w_ir = '0;
    for (int i = 0; i < 16; i++) begin
      w_ir[8*i +: 8] = r_buf[r_head + 5'(i)];
    end
  end

  // Byte storage: an accepted line always fills a whole 16-byte half, chosen by r_wrHalf.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 32; k++) begin
        r_buf[k] <= 8'h00;
      end
    end else if (w_fill) begin
      for (int k = 0; k < 16; k++) begin
        r_buf[{r_wrHalf, k[3:0]}] <= bus.IC_LINE[8*k +: 8];
      end
    end
  end

  // Control FSM: redirect wins over everything; ALIGN drops leading bytes of the first line, STREAM tracks occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ALIGN;
      r_head   <= 5'd0;
      r_count  <= 6'd0;
      r_wrHalf <= 1'b0;
      r_fa     <= RESET_EIP[31:4];
      r_eip    <= RESET_EIP;
      r_skip   <= RESET_EIP[3:0];
    end else if (bus.REDIRECT) begin
      r_state  <= ALIGN;
      r_head   <= 5'd0;
      r_count  <= 6'd0;
      r_wrHalf <= 1'b0;
      r_fa     <= bus.REDIRECT_EIP[31:4];
      r_eip    <= bus.REDIRECT_EIP;
      r_skip   <= bus.REDIRECT_EIP[3:0];
    end else begin
      if (w_fill) begin
        r_wrHalf <= ~r_wrHalf;
        r_fa     <= r_fa + 28'd1;
      end
      case (r_state)
        ALIGN: begin
          if (w_fill) begin
            r_head  <= {r_wrHalf, r_skip};
            r_count <= 6'd16 - {2'b00, r_skip};
            r_state <= STREAM;
          end
        end
        STREAM: begin
          r_count <= r_count + w_fillAmt - w_consAmt;
          if (w_consume) begin
            r_head <= r_head + {1'b0, bus.D_LENGTH};
            r_eip  <= r_eip + {28'd0, bus.D_LENGTH};
          end
        end
        default: r_state <= ALIGN;
      endcase
    end
  end

  assign bus.IC_ADDR  = {r_fa, 4'h0};
  assign bus.IC_READY = w_icReady;
  assign bus.IR       = w_ir;
  assign bus.IR_VALID = w_irValid;
  assign bus.EIP      = r_eip;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer with RESET_EIP = 0x1000.
module tb_fetch_align_buffer;

  logic clk = 1'b0;
  logic reset;
  int   nCompared = 0;
  int   nMismatched = 0;

  fetch_align_buffer_if fabIf ();

  fetch_align_buffer #(.RESET_EIP(32'h0000_1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fabIf)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Line whose byte k holds base + k
  function automatic logic [127:0] mkLine(input logic [7:0] base);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
    return l;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return all handshake inputs to their quiet values
  task automatic idle();
    fabIf.IC_VALID     = 1'b0;
    fabIf.IC_LINE      = '0;
    fabIf.D_CONSUME    = 1'b0;
    fabIf.D_LENGTH     = 4'd0;
    fabIf.REDIRECT     = 1'b0;
    fabIf.REDIRECT_EIP = 32'h0;
  endtask

  // Outputs while reset is held, then release away from the clock edge
  task automatic test_reset();
    reset = 1'b0;
    idle();
    #12;
    nCompared++; if (fabIf.IC_ADDR !== 32'h1000) begin nMismatched++; $display("[TB] FAIL reset_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h1000); end
    nCompared++; if (fabIf.IR_VALID !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b0); end
    nCompared++; if (fabIf.IC_READY !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_icready: got %h expected %h", fabIf.IC_READY, 1'b1); end
    nCompared++; if (fabIf.IR !== 128'h0) begin nMismatched++; $display("[TB] FAIL reset_ir: got %h expected %h", fabIf.IR, 128'h0); end
    nCompared++; if (fabIf.EIP !== 32'h1000) begin nMismatched++; $display("[TB] FAIL reset_eip: got %h expected %h", fabIf.EIP, 32'h1000); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Aligned first fill is visible right after its edge; zero-length consume is ignored
  task automatic test_first_fill();
    fabIf.IC_VALID = 1'b1;
    fabIf.IC_LINE  = mkLine(8'h00);
    tick();
    idle();
    nCompared++; if (fabIf.IR_VALID !== 1'b1) begin nMismatched++; $display("[TB] FAIL fill1_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b1); end
    nCompared++; if (fabIf.IR !== mkLine(8'h00)) begin nMismatched++; $display("[TB] FAIL fill1_ir: got %h expected %h", fabIf.IR, mkLine(8'h00)); end
    nCompared++; if (fabIf.EIP !== 32'h1000) begin nMismatched++; $display("[TB] FAIL fill1_eip: got %h expected %h", fabIf.EIP, 32'h1000); end
    nCompared++; if (fabIf.IC_ADDR !== 32'h1010) begin nMismatched++; $display("[TB] FAIL fill1_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h1010); end
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd0;
    tick();
    idle();
    nCompared++; if (fabIf.EIP !== 32'h1000) begin nMismatched++; $display("[TB] FAIL len0_eip: got %h expected %h", fabIf.EIP, 32'h1000); end
    nCompared++; if (dut.r_count !== 6'd16) begin nMismatched++; $display("[TB] FAIL len0_count: got %0d expected %0d", dut.r_count, 16); end
  endtask

  // Second line fills the buffer, then two consumes walk the head into the upper half
  task automatic test_streaming();
    fabIf.IC_VALID = 1'b1;
    fabIf.IC_LINE  = mkLine(8'h10);
    tick();
    idle();
    nCompared++; if (dut.r_count !== 6'd32) begin nMismatched++; $display("[TB] FAIL stream_full_count: got %0d expected %0d", dut.r_count, 32); end
    nCompared++; if (fabIf.IC_READY !== 1'b0) begin nMismatched++; $display("[TB] FAIL stream_full_icready: got %h expected %h", fabIf.IC_READY, 1'b0); end
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd3;
    tick();
    idle();
    nCompared++; if (fabIf.IR !== mkLine(8'h03)) begin nMismatched++; $display("[TB] FAIL cons3_ir: got %h expected %h", fabIf.IR, mkLine(8'h03)); end
    nCompared++; if (fabIf.EIP !== 32'h1003) begin nMismatched++; $display("[TB] FAIL cons3_eip: got %h expected %h", fabIf.EIP, 32'h1003); end
    nCompared++; if (dut.r_count !== 6'd29) begin nMismatched++; $display("[TB] FAIL cons3_count: got %0d expected %0d", dut.r_count, 29); end
    nCompared++; if (fabIf.IC_READY !== 1'b0) begin nMismatched++; $display("[TB] FAIL cons3_icready: got %h expected %h", fabIf.IC_READY, 1'b0); end
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd14;
    tick();
    idle();
    nCompared++; if (fabIf.IR[7:0] !== 8'h11) begin nMismatched++; $display("[TB] FAIL cons14_ir0: got %h expected %h", fabIf.IR[7:0], 8'h11); end
    nCompared++; if (fabIf.EIP !== 32'h1011) begin nMismatched++; $display("[TB] FAIL cons14_eip: got %h expected %h", fabIf.EIP, 32'h1011); end
    nCompared++; if (fabIf.IC_READY !== 1'b1) begin nMismatched++; $display("[TB] FAIL cons14_icready: got %h expected %h", fabIf.IC_READY, 1'b1); end
    nCompared++; if (fabIf.IR_VALID !== 1'b0) begin nMismatched++; $display("[TB] FAIL cons14_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b0); end
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd2;
    tick();
    idle();
    nCompared++; if (fabIf.EIP !== 32'h1011) begin nMismatched++; $display("[TB] FAIL stall_eip: got %h expected %h", fabIf.EIP, 32'h1011); end
  endtask

  // Redirect to an unaligned address needs two fills before decode sees a window
  task automatic test_redirect();
    fabIf.REDIRECT     = 1'b1;
    fabIf.REDIRECT_EIP = 32'h2005;
    #1;
    nCompared++; if (fabIf.IC_READY !== 1'b0) begin nMismatched++; $display("[TB] FAIL redir_icready: got %h expected %h", fabIf.IC_READY, 1'b0); end
    tick();
    idle();
    nCompared++; if (fabIf.IC_ADDR !== 32'h2000) begin nMismatched++; $display("[TB] FAIL redir_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h2000); end
    nCompared++; if (fabIf.EIP !== 32'h2005) begin nMismatched++; $display("[TB] FAIL redir_eip: got %h expected %h", fabIf.EIP, 32'h2005); end
    fabIf.IC_VALID = 1'b1;
    fabIf.IC_LINE  = mkLine(8'hA0);
    tick();
    idle();
    nCompared++; if (dut.r_count !== 6'd11) begin nMismatched++; $display("[TB] FAIL redir_fill1_count: got %0d expected %0d", dut.r_count, 11); end
    nCompared++; if (fabIf.IR_VALID !== 1'b0) begin nMismatched++; $display("[TB] FAIL redir_fill1_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b0); end
    nCompared++; if (fabIf.IC_ADDR !== 32'h2010) begin nMismatched++; $display("[TB] FAIL redir_fill1_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h2010); end
    fabIf.IC_VALID = 1'b1;
    fabIf.IC_LINE  = mkLine(8'hB0);
    tick();
    idle();
    nCompared++; if (fabIf.IR_VALID !== 1'b1) begin nMismatched++; $display("[TB] FAIL redir_fill2_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b1); end
    nCompared++; if (fabIf.IR !== mkLine(8'hA5)) begin nMismatched++; $display("[TB] FAIL redir_fill2_ir: got %h expected %h", fabIf.IR, mkLine(8'hA5)); end
    nCompared++; if (fabIf.EIP !== 32'h2005) begin nMismatched++; $display("[TB] FAIL redir_fill2_eip: got %h expected %h", fabIf.EIP, 32'h2005); end
  endtask

  // Fill and consume on the same edge with the window straddling byte 31->0
  task automatic test_fill_consume_wrap();
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd11;
    tick();
    idle();
    nCompared++; if (dut.r_count !== 6'd16) begin nMismatched++; $display("[TB] FAIL wrap_pre_count: got %0d expected %0d", dut.r_count, 16); end
    fabIf.IC_VALID  = 1'b1;
    fabIf.IC_LINE   = mkLine(8'hC0);
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd7;
    tick();
    idle();
    nCompared++; if (dut.r_count !== 6'd25) begin nMismatched++; $display("[TB] FAIL wrap_count: got %0d expected %0d", dut.r_count, 25); end
    nCompared++; if (fabIf.EIP !== 32'h2017) begin nMismatched++; $display("[TB] FAIL wrap_eip: got %h expected %h", fabIf.EIP, 32'h2017); end
    nCompared++; if (fabIf.IR !== mkLine(8'hB7)) begin nMismatched++; $display("[TB] FAIL wrap_ir: got %h expected %h", fabIf.IR, mkLine(8'hB7)); end
    nCompared++; if (fabIf.IC_ADDR !== 32'h2030) begin nMismatched++; $display("[TB] FAIL wrap_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h2030); end
  endtask

  // Held IC_VALID with count=20 must not be taken until count drops to 16
  task automatic test_backpressure();
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd5;
    tick();
    idle();
    fabIf.IC_VALID = 1'b1;
    fabIf.IC_LINE  = mkLine(8'hD0);
    for (int c = 0; c < 5; c++) begin
      tick();
      nCompared++; if (dut.r_count !== 6'd20) begin nMismatched++; $display("[TB] FAIL bp_hold_count: cycle %0d got %0d expected %0d", c, dut.r_count, 20); end
      nCompared++; if (fabIf.IC_ADDR !== 32'h2030) begin nMismatched++; $display("[TB] FAIL bp_hold_icaddr: cycle %0d got %h expected %h", c, fabIf.IC_ADDR, 32'h2030); end
    end
    fabIf.D_CONSUME = 1'b1;
    fabIf.D_LENGTH  = 4'd4;
    tick();
    fabIf.D_CONSUME = 1'b0;
    fabIf.D_LENGTH  = 4'd0;
    nCompared++; if (dut.r_count !== 6'd16) begin nMismatched++; $display("[TB] FAIL bp_drain_count: got %0d expected %0d", dut.r_count, 16); end
    nCompared++; if (fabIf.IC_ADDR !== 32'h2030) begin nMismatched++; $display("[TB] FAIL bp_drain_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h2030); end
    nCompared++; if (fabIf.EIP !== 32'h2020) begin nMismatched++; $display("[TB] FAIL bp_drain_eip: got %h expected %h", fabIf.EIP, 32'h2020); end
    tick();
    idle();
    nCompared++; if (dut.r_count !== 6'd32) begin nMismatched++; $display("[TB] FAIL bp_fill_count: got %0d expected %0d", dut.r_count, 32); end
    nCompared++; if (fabIf.IC_ADDR !== 32'h2040) begin nMismatched++; $display("[TB] FAIL bp_fill_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h2040); end
    nCompared++; if (fabIf.IR !== mkLine(8'hC0)) begin nMismatched++; $display("[TB] FAIL bp_fill_ir: got %h expected %h", fabIf.IR, mkLine(8'hC0)); end
  endtask

  // Redirect together with consume and line valid: only the redirect acts
  task automatic test_redirect_priority();
    fabIf.REDIRECT     = 1'b1;
    fabIf.REDIRECT_EIP = 32'h3000;
    fabIf.D_CONSUME    = 1'b1;
    fabIf.D_LENGTH     = 4'd2;
    fabIf.IC_VALID     = 1'b1;
    fabIf.IC_LINE      = mkLine(8'hE0);
    #1;
    nCompared++; if (fabIf.IC_READY !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_icready: got %h expected %h", fabIf.IC_READY, 1'b0); end
    tick();
    idle();
    nCompared++; if (dut.r_count !== 6'd0) begin nMismatched++; $display("[TB] FAIL prio_count: got %0d expected %0d", dut.r_count, 0); end
    nCompared++; if (dut.r_state !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_state: got %h expected ALIGN(0)", dut.r_state); end
    nCompared++; if (fabIf.EIP !== 32'h3000) begin nMismatched++; $display("[TB] FAIL prio_eip: got %h expected %h", fabIf.EIP, 32'h3000); end
    nCompared++; if (fabIf.IC_ADDR !== 32'h3000) begin nMismatched++; $display("[TB] FAIL prio_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h3000); end
    nCompared++; if (fabIf.IR_VALID !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b0); end
  endtask

  // Asynchronous reset mid-cycle, then the first fill lands at the reset line
  task automatic test_async_reset();
    fabIf.IC_VALID = 1'b1;
    fabIf.IC_LINE  = mkLine(8'hF0);
    tick();
    idle();
    nCompared++; if (fabIf.IR_VALID !== 1'b1) begin nMismatched++; $display("[TB] FAIL ar_pre_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b1); end
    #2;
    reset = 1'b0;
    #1;
    nCompared++; if (fabIf.IC_ADDR !== 32'h1000) begin nMismatched++; $display("[TB] FAIL ar_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h1000); end
    nCompared++; if (fabIf.EIP !== 32'h1000) begin nMismatched++; $display("[TB] FAIL ar_eip: got %h expected %h", fabIf.EIP, 32'h1000); end
    nCompared++; if (fabIf.IR !== 128'h0) begin nMismatched++; $display("[TB] FAIL ar_ir: got %h expected %h", fabIf.IR, 128'h0); end
    nCompared++; if (fabIf.IR_VALID !== 1'b0) begin nMismatched++; $display("[TB] FAIL ar_irvalid: got %h expected %h", fabIf.IR_VALID, 1'b0); end
    nCompared++; if (fabIf.IC_READY !== 1'b1) begin nMismatched++; $display("[TB] FAIL ar_icready: got %h expected %h", fabIf.IC_READY, 1'b1); end
    #2;
    reset = 1'b1;
    fabIf.IC_VALID = 1'b1;
    fabIf.IC_LINE  = mkLine(8'h40);
    tick();
    idle();
    nCompared++; if (fabIf.IC_ADDR !== 32'h1010) begin nMismatched++; $display("[TB] FAIL ar_fill_icaddr: got %h expected %h", fabIf.IC_ADDR, 32'h1010); end
    nCompared++; if (fabIf.IR !== mkLine(8'h40)) begin nMismatched++; $display("[TB] FAIL ar_fill_ir: got %h expected %h", fabIf.IR, mkLine(8'h40)); end
    nCompared++; if (fabIf.EIP !== 32'h1000) begin nMismatched++; $display("[TB] FAIL ar_fill_eip: got %h expected %h", fabIf.EIP, 32'h1000); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_first_fill();
    test_streaming();
    test_redirect();
    test_fill_consume_wrap();
    test_backpressure();
    test_redirect_priority();
    test_async_reset();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
